// File: rtl/eth_mdio_pkg.sv
// eth_mdio_pkg: shared types, frame constants and frame builder
// for the clause-22 MDIO management master.
package eth_mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    TA,
    DATA,
    DONE
  } state_t;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam int HDR_BITS  = 14;
  localparam int DATA_BITS = 16;

  // {ST, OP, PHYAD, REGAD, TA, DATA}; TA/DATA are
  // never driven on a read, so their content is filler.
  function automatic logic [31:0] build_frame(
    input logic        wr,
    input logic [4:0]  phy,
    input logic [4:0]  reg_a,
    input logic [15:0] wd
  );
    logic [1:0]  op;
    logic [1:0]  ta;
    logic [15:0] dat;
    op  = wr ? MDIO_OP_WR : MDIO_OP_RD;
    ta  = wr ? MDIO_TA_WR : 2'b11;
    dat = wr ? wd : 16'hFFFF;
    return {MDIO_ST, op, phy, reg_a, ta, dat};
  endfunction

endpackage

// File: rtl/eth_mdio_if.sv
// eth_mdio_if: request/response bundle of the MDIO master.
// master = requester side, slave = eth_mdio_master side.
interface eth_mdio_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_phy_addr;
  logic [4:0]  req_reg_addr;
  logic [15:0] req_wdata;
  logic        abort;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid,
    output req_write,
    output req_phy_addr,
    output req_reg_addr,
    output req_wdata,
    output abort,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_phy_addr,
    input  req_reg_addr,
    input  req_wdata,
    input  abort,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err,
    output busy
  );

endinterface

// File: rtl/eth_mdio_clkgen.sv
// eth_mdio_clkgen: MDC divider. Ports: msoc_clk, rstn, restart,
// run in; mdc, fall_tick, sample_tick (last high cycle) out.
module eth_mdio_clkgen #(
  parameter int CLK_DIV = 10
) (
  input  logic msoc_clk,
  input  logic rstn,
  input  logic restart,
  input  logic run,
  output logic mdc,
  output logic fall_tick,
  output logic sample_tick
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       phase_end;

  assign phase_end = (cnt == DIV_LAST);

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (restart || !run) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (phase_end) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // MDC falls right after the last high cycle, which is
  // also where the synchronised input is sampled.
  assign sample_tick = run && mdc && phase_end;
  assign fall_tick   = sample_tick;

endmodule

// File: rtl/eth_mdio_master.sv
// eth_mdio_master: clause-22 MDIO master. Ports: msoc_clk, rstn,
// bus (eth_mdio_if.slave), o_mdc, o_mdio, oe_mdio, i_mdio;
// no_preamble only with `define ETH_MDIO_PREAMBLE_SUPPRESS_EN.
module eth_mdio_master
  import eth_mdio_pkg::*;
#(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic    msoc_clk,
  input  logic    rstn,
  eth_mdio_if.slave bus,
`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
  input  logic    no_preamble,
`endif
  output logic    o_mdc,
  output logic    o_mdio,
  output logic    oe_mdio,
  input  logic    i_mdio
);

  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);
  localparam logic [5:0] HDR_LAST = 6'(HDR_BITS - 1);
  localparam logic [5:0] DAT_LAST = 6'(DATA_BITS - 1);

  state_t      state;
  logic [5:0]  bit_cnt;
  logic [31:0] sr;
  logic        wr_q;
  logic        err_flag;
  logic [14:0] rd_sh;
  logic        busy_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        mdio_q;
  logic        oe_q;
  logic [1:0]  sync;
  logic        mdi;
  logic        accept;
  logic        active;
  logic        run;
  logic        last_bit;
  logic        fall_tick;
  logic        sample_tick;

  assign accept = bus.req_valid && bus.req_ready;
  assign active = state inside {PREAMBLE, HEADER, TA, DATA};
  assign run    = active && !bus.abort;
  assign mdi    = sync[1];

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign o_mdio        = mdio_q;
  assign oe_mdio       = oe_q;

  eth_mdio_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .msoc_clk    (msoc_clk),
    .rstn        (rstn),
    .restart     (accept),
    .run         (run),
    .mdc         (o_mdc),
    .fall_tick   (fall_tick),
    .sample_tick (sample_tick)
  );

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) sync <= 2'b11;
    else       sync <= {sync[0], i_mdio};
  end

  always_comb begin
    last_bit = 1'b0;
    unique case (state)
      PREAMBLE: last_bit = (bit_cnt == PRE_LAST);
      HEADER:   last_bit = (bit_cnt == HDR_LAST);
      TA:       last_bit = (bit_cnt == 6'd1);
      DATA:     last_bit = (bit_cnt == DAT_LAST);
      default:  last_bit = 1'b0;
    endcase
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      sr          <= '0;
      wr_q        <= 1'b0;
      err_flag    <= 1'b0;
      rd_sh       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mdio_q      <= 1'b1;
      oe_q        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            sr <= build_frame(bus.req_write,
                              bus.req_phy_addr,
                              bus.req_reg_addr,
                              bus.req_wdata);
            wr_q     <= bus.req_write;
            err_flag <= 1'b0;
            rd_sh    <= '0;
            bit_cnt  <= '0;
            busy_q   <= 1'b1;
            oe_q     <= 1'b1;
`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
            if (no_preamble) begin
              state  <= HEADER;
              mdio_q <= MDIO_ST[1];
            end else
`endif
            begin
              state  <= PREAMBLE;
              mdio_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          if (bus.abort) begin
            state       <= DONE;
            oe_q        <= 1'b0;
            mdio_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            if (sample_tick && !wr_q) begin
              if (state == TA && bit_cnt == 6'd1)
                err_flag <= mdi;
              if (state == DATA)
                rd_sh <= {rd_sh[13:0], mdi};
            end
            if (fall_tick && last_bit) begin
              bit_cnt <= '0;
              unique case (state)
                PREAMBLE: begin
                  state  <= HEADER;
                  mdio_q <= sr[31];
                end
                HEADER, TA: begin
                  state  <= (state == HEADER) ? TA : DATA;
                  sr     <= sr << 1;
                  mdio_q <= wr_q ? sr[30] : 1'b1;
                  oe_q   <= wr_q;
                end
                default: begin
                  state       <= DONE;
                  mdio_q      <= 1'b1;
                  oe_q        <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= wr_q ? 1'b0 : err_flag;
                  rsp_rdata_q <= wr_q ? 16'h0000
                                      : {rd_sh, mdi};
                end
              endcase
            end else if (fall_tick) begin
              bit_cnt <= bit_cnt + 6'd1;
              if (state != PREAMBLE) begin
                sr     <= sr << 1;
                mdio_q <= (state == HEADER || wr_q)
                          ? sr[30] : 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_mdio_master.sv
// tb_eth_mdio_master: randomized self-checking bench with a
// bit-level MDIO frame model and a simple PHY responder.
module tb_eth_mdio_master;

  localparam int CD  = 4;
  localparam int PRE = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic o_mdc, o_mdio, oe_mdio;
  logic i_mdio = 1'b1;
  logic no_pre = 1'b0;

  eth_mdio_if bus();

  eth_mdio_master #(.CLK_DIV(CD), .PREAMBLE_LEN(PRE)) dut (
    .msoc_clk (clk),
    .rstn     (rstn),
    .bus      (bus),
`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
    .no_preamble (no_pre),
`endif
    .o_mdc    (o_mdc),
    .o_mdio   (o_mdio),
    .oe_mdio  (oe_mdio),
    .i_mdio   (i_mdio)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc_q[$];
  int rsp_cyc_q[$];
  bit trace_mdio[$];
  bit trace_oe[$];
  int bit_idx = 0;
  logic mdc_prev = 1'b0;
  bit phy_on = 0;
  bit phy_bits[64];

  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor and PHY responder (new bit value at MDC fall).
  always @(negedge clk) begin
    if (rstn && bus.req_valid && bus.req_ready) begin
      acc_cyc_q.push_back(cyc);
      trace_mdio.delete();
      trace_oe.delete();
      bit_idx = 0;
    end else if (o_mdc && !mdc_prev) begin
      trace_mdio.push_back(o_mdio);
      trace_oe.push_back(oe_mdio);
    end else if (!o_mdc && mdc_prev) begin
      bit_idx++;
    end
    if (bus.rsp_valid) rsp_cyc_q.push_back(cyc);
    mdc_prev = o_mdc;
    i_mdio = (phy_on && bit_idx < 64) ? phy_bits[bit_idx] : 1'b1;
  end

  task automatic idle_bus();
    bus.req_valid = 0;
    bus.req_write = 0;
    bus.req_phy_addr = '0;
    bus.req_reg_addr = '0;
    bus.req_wdata = '0;
    bus.abort = 0;
  endtask

  task automatic wait_rsp(input int n_rsp, input string nm);
    for (int i = 0; i < 4000 && rsp_cyc_q.size() <= n_rsp; i++)
      @(posedge clk);
    #1;
    checks++;
    if (rsp_cyc_q.size() <= n_rsp) begin
      failures++;
      $display("FAIL %s_timeout: got no rsp_valid want one", nm);
    end
  endtask

  task automatic run_txn(input string nm, input bit wr,
                         input logic [4:0] phy, input logic [4:0] ra,
                         input logic [15:0] d, input bit present,
                         input bit nopre);
    int n_acc, n_rsp, pre, lat, mism;
    bit em[$];
    bit eo[$];
    logic [15:0] exp_rd;
    logic exp_err;
    pre = nopre ? 0 : PRE;
    for (int i = 0; i < 64; i++) phy_bits[i] = 1'b1;
    if (present) begin
      phy_bits[pre + 15] = 1'b0;
      for (int i = 0; i < 16; i++) phy_bits[pre + 16 + i] = d[15 - i];
    end
    phy_on = !wr;
    repeat (pre) begin em.push_back(1); eo.push_back(1); end
    em.push_back(0); em.push_back(1);
    em.push_back(!wr); em.push_back(wr);
    for (int i = 4; i >= 0; i--) em.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) em.push_back(ra[i]);
    repeat (14) eo.push_back(1);
    em.push_back(1); em.push_back(0);
    for (int i = 15; i >= 0; i--) em.push_back(d[i]);
    repeat (18) eo.push_back(wr);
    exp_rd  = wr ? 16'h0 : (present ? d : 16'hFFFF);
    exp_err = wr ? 1'b0 : !present;
    n_acc = acc_cyc_q.size();
    n_rsp = rsp_cyc_q.size();
    @(posedge clk); #1;
    bus.req_write = wr;
    bus.req_phy_addr = phy;
    bus.req_reg_addr = ra;
    bus.req_wdata = d;
    bus.req_valid = 1;
    no_pre = nopre;
    @(posedge clk); #1;
    bus.req_valid = 0;
    no_pre = 0;
    wait_rsp(n_rsp, nm);
    checks++;
    if (acc_cyc_q.size() !== n_acc + 1) begin
      failures++;
      $display("FAIL %s_accepts: got %0d want %0d", nm,
               acc_cyc_q.size() - n_acc, 1);
    end
    if (rsp_cyc_q.size() > n_rsp && acc_cyc_q.size() > n_acc) begin
      lat = rsp_cyc_q[n_rsp] - acc_cyc_q[n_acc];
      checks++;
      if (lat !== (pre + 32) * 2 * CD + 1) begin
        failures++;
        $display("FAIL %s_latency: got %0d want %0d", nm, lat,
                 (pre + 32) * 2 * CD + 1);
      end
    end
    checks++;
    if (bus.rsp_rdata !== exp_rd) begin
      failures++;
      $display("FAIL %s_rdata: got %h want %h", nm, bus.rsp_rdata,
               exp_rd);
    end
    checks++;
    if (bus.rsp_err !== exp_err) begin
      failures++;
      $display("FAIL %s_err: got %b want %b", nm, bus.rsp_err, exp_err);
    end
    checks++;
    if (trace_oe.size() !== eo.size()) begin
      failures++;
      $display("FAIL %s_bits: got %0d want %0d", nm, trace_oe.size(),
               eo.size());
    end
    mism = 0;
    for (int i = 0; i < eo.size() && i < trace_oe.size(); i++) begin
      if (trace_oe[i] !== eo[i]) mism++;
      if (eo[i] && trace_mdio[i] !== em[i]) mism++;
    end
    checks++;
    if (mism !== 0) begin
      failures++;
      $display("FAIL %s_trace: got %0d bad bits want 0", nm, mism);
    end
  endtask

  task automatic test_reset();
    idle_bus();
    rstn = 0;
    #23;
    checks++;
    if ({o_mdc, o_mdio, oe_mdio, bus.busy, bus.rsp_valid, bus.rsp_err,
         bus.rsp_rdata, bus.req_ready} !== {6'b010000, 16'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_vals: got %b%b%b%b%b%b %h want 010000 0000",
               o_mdc, o_mdio, oe_mdio, bus.busy, bus.rsp_valid,
               bus.rsp_err, bus.rsp_rdata);
    end
    @(posedge clk); #1;
    rstn = 1;
  endtask

  task automatic test_write_fixed();
    run_txn("wr_fixed", 1, 5'd1, 5'd0, 16'h1200, 0, 0);
  endtask

  task automatic test_read_fixed();
    run_txn("rd_fixed", 0, 5'd3, 5'd2, 16'h0022, 1, 0);
  endtask

  task automatic test_read_nophy();
    run_txn("rd_nophy", 0, 5'd7, 5'd9, 16'h0000, 0, 0);
  endtask

  task automatic test_busy();
    int n_acc, n_rsp;
    n_acc = acc_cyc_q.size();
    n_rsp = rsp_cyc_q.size();
    phy_on = 0;
    @(posedge clk); #1;
    bus.req_write = 1;
    bus.req_wdata = 16'hA5A5;
    bus.req_valid = 1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_accept_cycle: got %b want 0", bus.busy);
    end
    @(posedge clk); #1;
    bus.req_valid = 0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL busy_after: got %b%b want 10", bus.busy,
               bus.req_ready);
    end
    repeat (50) @(posedge clk);
    #1 bus.req_valid = 1;
    repeat (20) @(posedge clk);
    #1 bus.req_valid = 0;
    @(negedge clk);
    checks++;
    if ({bus.rsp_rdata, bus.rsp_err} !== {16'hFFFF, 1'b1}) begin
      failures++;
      $display("FAIL rsp_hold: got %h %b want ffff 1", bus.rsp_rdata,
               bus.rsp_err);
    end
    checks++;
    if (acc_cyc_q.size() !== n_acc + 1) begin
      failures++;
      $display("FAIL busy_ignore: got %0d accepts want 1",
               acc_cyc_q.size() - n_acc);
    end
    wait_rsp(n_rsp, "busy");
    checks++;
    if ({bus.rsp_rdata, bus.rsp_err} !== 17'h0) begin
      failures++;
      $display("FAIL busy_wr_rsp: got %h %b want 0000 0", bus.rsp_rdata,
               bus.rsp_err);
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    bit wr, pres;
    for (int k = 0; k < 6; k++) begin
      wr = 1'($urandom_range(0, 1));
      pres = ($urandom_range(0, 3) != 0);
      d = 16'($urandom());
      run_txn($sformatf("rand%0d", k), wr, 5'($urandom()),
              5'($urandom()), d, pres, 0);
    end
  endtask

  task automatic test_back_to_back();
    int n_acc, n_rsp;
    n_acc = acc_cyc_q.size();
    n_rsp = rsp_cyc_q.size();
    phy_on = 0;
    @(posedge clk); #1;
    bus.req_write = 1;
    bus.req_phy_addr = 5'd4;
    bus.req_wdata = 16'h3C3C;
    bus.req_valid = 1;
    for (int i = 0; i < 3000 && acc_cyc_q.size() < n_acc + 2; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    bus.req_valid = 0;
    wait_rsp(n_rsp + 1, "b2b");
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (acc_cyc_q.size() !== n_acc + 2 ||
        rsp_cyc_q.size() !== n_rsp + 2) begin
      failures++;
      $display("FAIL b2b_counts: got %0d/%0d want 2/2",
               acc_cyc_q.size() - n_acc, rsp_cyc_q.size() - n_rsp);
    end else begin
      checks++;
      if (acc_cyc_q[n_acc + 1] !== rsp_cyc_q[n_rsp] + 1) begin
        failures++;
        $display("FAIL b2b_gap: got %0d want %0d", acc_cyc_q[n_acc + 1],
                 rsp_cyc_q[n_rsp] + 1);
      end
    end
  endtask

  task automatic test_abort();
    int n_rsp;
    bit hit;
    n_rsp = rsp_cyc_q.size();
    phy_on = 0;
    @(posedge clk); #1;
    bus.req_write = 1;
    bus.req_wdata = 16'hFFFF;
    bus.req_valid = 1;
    @(posedge clk); #1;
    bus.req_valid = 0;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge clk); #1;
      hit = (bit_idx == PRE + 16 + 5) && o_mdc;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL abort_reach: got no data bit 5 want it");
    end
    bus.abort = 1;
    @(posedge clk); #1;
    bus.abort = 0;
    checks++;
    if ({o_mdc, oe_mdio, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}
        !== {4'b0011, 16'h0}) begin
      failures++;
      $display("FAIL abort_next: got %b%b%b%b %h want 0011 0000", o_mdc,
               oe_mdio, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL abort_done: got %b%b want 01", bus.rsp_valid,
               bus.req_ready);
    end
    n_rsp = rsp_cyc_q.size();
    bus.abort = 1;
    @(posedge clk); #1;
    bus.abort = 0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (rsp_cyc_q.size() !== n_rsp || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: got %0d rsp busy %b want 0 0",
               rsp_cyc_q.size() - n_rsp, bus.busy);
    end
    bus.abort = 1;
    bus.req_valid = 1;
    @(posedge clk); #1;
    bus.abort = 0;
    bus.req_valid = 0;
    wait_rsp(n_rsp, "abort_acc");
    checks++;
    if (bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL abort_accept: got err %b want 0", bus.rsp_err);
    end
  endtask

  task automatic test_reset_midframe();
    int n_rsp;
    bit hit;
    n_rsp = rsp_cyc_q.size();
    phy_on = 0;
    @(posedge clk); #1;
    bus.req_write = 1;
    bus.req_wdata = 16'h8001;
    bus.req_valid = 1;
    @(posedge clk); #1;
    bus.req_valid = 0;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge clk); #1;
      hit = (bit_idx >= 40) && o_mdc && oe_mdio;
    end
    #2 rstn = 0;
    #1;
    checks++;
    if ({o_mdc, o_mdio, oe_mdio, bus.busy, bus.rsp_valid, bus.rsp_err,
         bus.rsp_rdata, bus.req_ready} !== {6'b010000, 16'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid: got %b%b%b%b%b%b %h want 010000 0000",
               o_mdc, o_mdio, oe_mdio, bus.busy, bus.rsp_valid,
               bus.rsp_err, bus.rsp_rdata);
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    repeat (700) @(posedge clk);
    #1;
    checks++;
    if (rsp_cyc_q.size() !== n_rsp || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_norsp: got %0d rsp ready %b want 0 1",
               rsp_cyc_q.size() - n_rsp, bus.req_ready);
    end
  endtask

`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
  task automatic test_no_preamble();
    run_txn("nopre_wr", 1, 5'd1, 5'd0, 16'h1200, 0, 1);
    run_txn("nopre_rd", 0, 5'd2, 5'd5, 16'hBEEF, 1, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_write_fixed();
    test_read_fixed();
    test_read_nophy();
    test_busy();
    test_random();
    test_back_to_back();
    test_abort();
    test_read_fixed();
    test_reset_midframe();
`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
    test_no_preamble();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_mdio_master.md
Name: eth_mdio_master

Overview:
- Hardware IEEE 802.3 clause-22 MDIO management master for the RMII Ethernet PHY, sitting beside the framing datapath in the msoc_clk domain.
- Replaces software bit-banging of MDC/MDIO through the framing control register.
- Accepts one read/write request at a time, serialises the 64-bit management frame on MDC/MDIO, and returns read data plus a no-PHY error flag.

Parameters:
- CLK_DIV, 10, msoc_clk cycles per MDC half-period; legal range 4..255.
- PREAMBLE_LEN, 32, number of preamble '1' bits sent before ST; legal range 1..32.

Ports:
- msoc_clk  in  1  block clock
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_write  in  1  1 = write, 0 = read
- req_phy_addr  in  5  PHYAD
- req_reg_addr  in  5  REGAD
- req_wdata  in  16  write data
- abort  in  1  terminate current transaction
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  read data; 0 for writes
- rsp_err  out  1  read TA not driven low by PHY, or aborted
- busy  out  1  transaction in progress
- o_mdc  out  1  management clock
- o_mdio  out  1  MDIO output value
- oe_mdio  out  1  MDIO output enable
- i_mdio  in  1  MDIO pad input; asynchronous, 2-flop synchronised internally

Behaviour:
- Reset values: o_mdc=0, o_mdio=1, oe_mdio=0, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
- Reset mid-transaction aborts immediately, with no response.
- Handshake: a request is accepted on a cycle where req_valid and req_ready are both high. All req_* fields are latched into a 32-bit shift register {ST=01, OP, PHYAD, REGAD, TA, DATA}.
  - OP=10 for read, 01 for write.
  - TA=10 for write; TA bits are don't-care for read.
- busy rises the cycle after accept. req_valid while busy is ignored (req_ready=0).
- Bit timing: each frame bit occupies one MDC period of 2*CLK_DIV cycles, low phase then high phase.
  - o_mdio and oe_mdio update on the cycle o_mdc goes low.
  - i_mdio (synchronised) is sampled on the last cycle of the high phase.
  - The MDC divider counter restarts at accept, so the first low phase is exactly CLK_DIV cycles.
- States:
  - IDLE: o_mdc=0, oe_mdio=0. Accept -> PREAMBLE.
  - PREAMBLE: drive '1' for PREAMBLE_LEN bits, oe_mdio=1 -> HEADER.
  - HEADER: shift out 14 bits (ST, OP, PHYAD, REGAD) MSB first -> TA.
  - TA:
    - write: drive 1 then 0.
    - read: oe_mdio=0 for both bits, and sample the second bit. If the sample is 1, set err_flag.
    - -> DATA.
  - DATA: 16 bits MSB first.
    - write: drive req_wdata.
    - read: oe_mdio=0, shift sampled bits into rdata.
    - -> DONE.
  - DONE: o_mdc=0, oe_mdio=0. rsp_valid=1 for one cycle with rsp_rdata/rsp_err -> IDLE.
- rsp_rdata and rsp_err hold their values until the next rsp_valid.
- Latency: accept to rsp_valid = (PREAMBLE_LEN+32)*2*CLK_DIV + 1 cycles. Default parameters give 1281.
- Back-to-back: req_ready is high the cycle after rsp_valid, so a new accept can occur then.
- abort while busy:
  - next cycle: o_mdc=0, oe_mdio=0, enter DONE.
  - rsp_valid pulse with rsp_err=1, rsp_rdata=0.
  - abort in IDLE is ignored.
  - abort and accept in the same cycle: accept wins.
- Counters: bit counter is 6 bits and the divider counter is 8 bits. Neither wraps within a frame. Terminal counts are compared with ==, not overflow.

Optional Feature:
- Macro ETH_MDIO_PREAMBLE_SUPPRESS_EN.
- Defined: extra input port no_preamble (1 bit), latched at accept. When the latched value is 1, the PREAMBLE state is skipped (IDLE -> HEADER), and latency shrinks by PREAMBLE_LEN*2*CLK_DIV.
- Undefined: port absent; a full preamble is always sent.

Decomposition:
- Package eth_mdio_pkg:
  - state enum (IDLE, PREAMBLE, HEADER, TA, DATA, DONE)
  - constants MDIO_ST=2'b01, MDIO_OP_RD=2'b10, MDIO_OP_WR=2'b01, MDIO_TA_WR=2'b10
  - field widths HDR_BITS=14, DATA_BITS=16
- One sub-module, eth_mdio_clkgen: divider counter, o_mdc generation, and single-cycle fall_tick/sample_tick outputs, with a restart input.

Test Plan:
- CLK_DIV=4, write PHY=1, REG=0, data=0x1200 -> MDIO trace = 32×'1', 01 01 00001 00000 10 0001001000000000; oe_mdio high throughout; rsp_valid at cycle 513 with rsp_err=0, rsp_rdata=0.
- Read PHY=3, REG=2, PHY model drives TA=0 and data 0x0022 -> oe_mdio=0 from TA through DATA; rsp_rdata=0x0022, rsp_err=0.
- Read with no PHY model (i_mdio pulled to 1) -> rsp_err=1, rsp_rdata=0xFFFF.
- req_valid held high across a full transaction -> exactly two accepts, second accept on the cycle after the first rsp_valid; no request dropped or duplicated.
- abort during DATA bit 5 -> next cycle o_mdc=0, oe_mdio=0; rsp_valid with rsp_err=1, rsp_rdata=0; then rstn asserted mid-frame -> all outputs at reset values asynchronously.
- With ETH_MDIO_PREAMBLE_SUPPRESS_EN, no_preamble=1, CLK_DIV=4 -> first MDIO bits are 0,1 (ST); rsp_valid at cycle 257.
